// File: rtl/trace_gen.sv
// Retire-trace producer: three per-channel event FIFOs (retire, writeback, redirect)
// drained together into one registered trace record with consumer backpressure.

module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

module trace_gen #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst_pc,
  input  logic [31:0] inst_word,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [31:0] br_pc,
  input  logic        trace_ready,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        rdv,
  output logic [4:0]  rd_x,
  output logic [31:0] rd_data,
  output logic        pcv,
  output logic [31:0] pc_x,
  output logic [31:0] instret
);
  logic        alive_q;
  logic        valid_q, rdv_q, pcv_q;
  logic [31:0] pc_q, inst_q, rd_data_q, pc_x_q, instret_q;
  logic [4:0]  rd_x_q;

  logic        inst_full, inst_empty, wb_full, wb_empty, br_full, br_empty;
  logic [63:0] inst_head;
  logic [36:0] wb_head;
  logic [31:0] br_head;
  logic        advance_d;

  // Readies stay low until the first edge after reset release.
  assign inst_ready = alive_q && !inst_full;
  assign wb_ready   = alive_q && !wb_full;
  assign br_ready   = alive_q && !br_full;

  assign advance_d = !(valid_q || rdv_q || pcv_q) || trace_ready;

  trace_fifo #(.DEPTH(DEPTH), .W(64)) u_inst_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inst_valid && inst_ready),
    .pop   (advance_d),
    .wdata ({inst_pc, inst_word}),
    .rdata (inst_head),
    .full  (inst_full),
    .empty (inst_empty)
  );

  // x0 writebacks are handshaken normally but never enter the queue.
  trace_fifo #(.DEPTH(DEPTH), .W(37)) u_wb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wb_valid && wb_ready && (wb_rd != 5'd0)),
    .pop   (advance_d),
    .wdata ({wb_rd, wb_data}),
    .rdata (wb_head),
    .full  (wb_full),
    .empty (wb_empty)
  );

  trace_fifo #(.DEPTH(DEPTH), .W(32)) u_br_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (br_valid && br_ready),
    .pop   (advance_d),
    .wdata (br_pc),
    .rdata (br_head),
    .full  (br_full),
    .empty (br_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive_q   <= 1'b0;
      valid_q   <= 1'b0;
      rdv_q     <= 1'b0;
      pcv_q     <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      rd_x_q    <= '0;
      rd_data_q <= '0;
      pc_x_q    <= '0;
      instret_q <= '0;
    end else begin
      alive_q <= 1'b1;
      if (valid_q && trace_ready) instret_q <= instret_q + 32'd1;
      if (advance_d) begin
        valid_q <= !inst_empty;
        rdv_q   <= !wb_empty;
        pcv_q   <= !br_empty;
        if (!inst_empty) begin
          pc_q   <= inst_head[63:32];
          inst_q <= inst_head[31:0];
        end
        if (!wb_empty) begin
          rd_x_q    <= wb_head[36:32];
          rd_data_q <= wb_head[31:0];
        end
        if (!br_empty) pc_x_q <= br_head;
      end
    end
  end

  assign valid   = valid_q;
  assign pc      = pc_q;
  assign inst    = inst_q;
  assign rdv     = rdv_q;
  assign rd_x    = rd_x_q;
  assign rd_data = rd_data_q;
  assign pcv     = pcv_q;
  assign pc_x    = pc_x_q;
  assign instret = instret_q;
endmodule

// File: doc/trace_gen.md
Name: trace_gen

Overview:
- Producer side of the per-cycle retire-trace interface (valid/pc/inst, rdv/rd_x/rd_data, pcv/pc_x) consumed by the simulation trace printer.
- Sits in the core next to the execute/writeback stages and collects three independent event streams: instruction retire, register writeback and PC redirect.
- Buffers each stream in its own FIFO and emits time-aligned trace records through a registered output stage with downstream backpressure.
- Also maintains a retired-instruction counter.

Parameters:
- DEPTH, 4: entries per channel FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_valid  in  1  retire event offered.
- inst_ready  out  1  retire FIFO not full.
- inst_pc  in  32  PC of the retired instruction.
- inst_word  in  32  instruction encoding.
- wb_valid  in  1  writeback event offered.
- wb_ready  out  1  writeback FIFO not full.
- wb_rd  in  5  destination register.
- wb_data  in  32  written value.
- br_valid  in  1  PC redirect event offered.
- br_ready  out  1  redirect FIFO not full.
- br_pc  in  32  redirect target.
- trace_ready  in  1  consumer accepts the current record.
- valid  out  1  record carries an instruction.
- pc  out  32  instruction PC.
- inst  out  32  instruction word.
- rdv  out  1  record carries a writeback.
- rd_x  out  5  writeback register.
- rd_data  out  32  writeback value.
- pcv  out  1  record carries a redirect.
- pc_x  out  32  redirect target.
- instret  out  32  count of instruction records accepted by the consumer.

Behaviour:
- **Reset (asynchronous, reset==0).**
  - All FIFOs empty.
  - valid, rdv, pcv = 0.
  - pc, inst, rd_x, rd_data, pc_x = 0.
  - instret = 0.
  - inst_ready, wb_ready, br_ready = 0 while reset is asserted, then 1 in the first cycle after release.
  - Reset mid-operation discards all queued events and the output record.
- **Input channels.**
  - Each channel uses a valid/ready handshake. A push happens on a rising edge where valid&&ready.
  - ready = !full. It does not depend on the same-cycle pop, so a full FIFO does not accept a push even while being popped.
  - A writeback with wb_rd==0 is accepted (wb_ready as normal) but not queued: x0 writes never appear in the trace.
  - FIFO pointers are log2(DEPTH)+1 bits. Full means the indices match and the wrap bits differ; empty means the pointers are equal.
- **Output stage.**
  - Registered. "Output empty" = !(valid|rdv|pcv).
  - Advance condition: output empty, or trace_ready==1.
  - On advance, each output field group loads the head of its FIFO and that FIFO is popped if non-empty. Its valid bit is set to non-empty; if empty, the valid bit is 0 and the data fields hold their previous values.
  - With no advance, all outputs hold stable. Valid bits must not drop while trace_ready==0.
  - All three channels advance together. One record therefore carries at most one instruction, one writeback and one redirect, matching the printer's single-line format.
- **Latency.**
  - An event pushed at edge N is visible on the outputs after edge N+1 at the earliest, i.e. 2 cycles.
  - The stage is fully pipelined: with trace_ready held 1 and a continuous input stream, each channel sustains 1 event per cycle.
- **Ordering.** FIFO order is preserved within each channel. No ordering is guaranteed across channels beyond the simultaneous-pop rule.
- **Push and pop in the same cycle.** Allowed when the FIFO is non-full and non-empty; occupancy is unchanged.
- **instret.**
  - Increments by 1 on each edge where valid&&trace_ready. Wraps modulo 2^32.
  - rdv/pcv-only records do not count.
- **No combinational paths.** No combinational path from any input to any output except through registers. ready depends only on FIFO state.

Test Plan:
- **Reset values:** assert reset for 3 cycles and release → all outputs 0, all ready=1 in the first cycle after release.
- **Single retire:** push inst_pc=0x00000100, inst_word=0x00500093 with trace_ready=1 → valid=1, pc=0x100, inst=0x00500093 exactly 2 cycles later for one cycle; instret=1 after that cycle.
- **Combined record:** same edge push inst (pc 0x104), wb (rd=1, data=0x5) and br (pc 0x200) → one record with valid=rdv=pcv=1, rd_x=1, rd_data=0x5, pc_x=0x200.
- **x0 filtering:** push wb rd=0, data=0xDEADBEEF → wb_ready=1, no record with rdv=1 ever appears.
- **Backpressure and full:**
  - Hold trace_ready=0 and push 6 retire events with DEPTH=4 → first record held stable; inst_ready drops after the FIFO fills (1 in the output stage plus 4 queued).
  - Release trace_ready → 5 records emitted in order on consecutive cycles; instret=5.
- **Reset mid-stream:** with 3 events queued, assert reset asynchronously between edges → outputs 0 immediately; no queued record is emitted after release.
